// File: rtl/cmp_arbiter_pkg.sv
// Shared constants, output-state enum and sign-conditioning helper for cmp_arbiter.
// Build option: define CMP_ARB_RR_EN for round-robin arbitration (fixed priority otherwise).
package cmp_arbiter_pkg;

    localparam int         CMP_DW = 32;
    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b10;
    localparam logic [1:0] CMP_LT = 2'b01;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Flipping the MSB maps two's-complement order onto unsigned order.
    function automatic logic [CMP_DW-1:0] sign_cond(input logic [CMP_DW-1:0] v, input logic s);
        return {v[CMP_DW-1] ^ s, v[CMP_DW-2:0]};
    endfunction

endpackage

// File: rtl/cmp.sv
// Unsigned 32-bit magnitude comparator shared by all requesters of cmp_arbiter.
module cmp
    import cmp_arbiter_pkg::*;
(
    input  logic [CMP_DW-1:0] a,
    input  logic [CMP_DW-1:0] b,
    output logic [1:0]        res
);

    always_comb begin
        if (a > b) begin
            res = CMP_GT;
        end else if (a < b) begin
            res = CMP_LT;
        end else begin
            res = CMP_EQ;
        end
    end

endmodule

// File: rtl/cmp_rr_pick.sv
// Request picker for cmp_arbiter: fixed priority by default, round-robin when
// CMP_ARB_RR_EN is defined (search starts just after ptr).
module cmp_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic found;

`ifdef CMP_ARB_RR_EN
    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (enable && !found && req[IDX_W'(idx)]) begin
                gnt[IDX_W'(idx)] = 1'b1;
                gnt_idx          = IDX_W'(idx);
                found            = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (enable && !found && req[IDX_W'(i)]) begin
                gnt[IDX_W'(i)] = 1'b1;
                gnt_idx        = IDX_W'(i);
                found          = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/cmp_arbiter.sv
// Shares one cmp between N_REQ requesters with a one-entry valid/ready result register.
// Build option: CMP_ARB_RR_EN selects round-robin arbitration; fixed priority otherwise.
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int DW    = CMP_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req_valid,
    input  logic [N_REQ-1:0]  req_signed,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic [N_REQ-1:0]  req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_res,
    output logic [N_REQ-1:0]  rsp_gnt
);

    localparam int IDX_W = $clog2(N_REQ);

    out_state_t        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  gnt_idx;
    logic [N_REQ-1:0]  gnt;
    logic              can_accept;
    logic              pick_en;
    logic              accept;
    logic [DW-1:0]     op_a;
    logic [DW-1:0]     op_b;
    logic              op_signed;
    logic [CMP_DW-1:0] cmp_a;
    logic [CMP_DW-1:0] cmp_b;
    logic [1:0]        cmp_res;

    // Grant only when the result register can take a new entry this cycle.
    assign can_accept = (state == OUT_EMPTY) | rsp_ready;
    assign pick_en    = can_accept & ~rst;

    cmp_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .enable  (pick_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    assign op_a      = req_a[gnt_idx*DW +: DW];
    assign op_b      = req_b[gnt_idx*DW +: DW];
    assign op_signed = req_signed[gnt_idx];
    assign cmp_a     = sign_cond(op_a, op_signed);
    assign cmp_b     = sign_cond(op_b, op_signed);

    cmp u_cmp (
        .a   (cmp_a),
        .b   (cmp_b),
        .res (cmp_res)
    );

`ifndef CMP_ARB_RR_EN
    assign ptr = IDX_W'(N_REQ - 1);
`endif

    // Output register; the pointer only moves on an accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= OUT_EMPTY;
            rsp_res <= CMP_EQ;
            rsp_gnt <= '0;
`ifdef CMP_ARB_RR_EN
            ptr     <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            case (state)
                OUT_EMPTY: if (accept) state <= OUT_FULL;
                OUT_FULL:  if (rsp_ready && !accept) state <= OUT_EMPTY;
            endcase
            if (accept) begin
                rsp_res <= cmp_res;
                rsp_gnt <= gnt;
`ifdef CMP_ARB_RR_EN
                ptr     <= gnt_idx;
`endif
            end
        end
    end

    assign rsp_valid = (state == OUT_FULL);

endmodule
